// File: rtl/stego_encoder.sv
// Stego encoder: hides a length header and then a payload in bits [1:0] of
// a stream of cover bytes, two bits per cover byte, MS pair first.
module stego_encoder #(
  parameter int LEN_W     = 24,
  parameter bit PASS_THRU = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_bits_i,
  input  logic [7:0]       pay_data_i,
  input  logic             pay_valid_i,
  output logic             pay_ready_o,
  input  logic [7:0]       cov_data_i,
  input  logic             cov_valid_i,
  output logic             cov_ready_o,
  output logic [7:0]       st_data_o,
  output logic             st_valid_o,
  input  logic             st_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] bytes_done_o
);

  localparam int HDR_BYTES = LEN_W / 8;
  localparam int HW        = $clog2(HDR_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_EMBED,
    S_PASS
  } state_e;

  localparam state_e S_EXIT = PASS_THRU ? S_PASS : S_IDLE;

  state_e           state_q, state_d;
  logic [7:0]       sym_q, sym_d;
  logic [1:0]       p_q, p_d;
  logic [HW-1:0]    h_q, h_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] hdr_q, hdr_d;
  logic [LEN_W-1:0] bytes_done_q, bytes_done_d;
  logic [7:0]       st_data_q, st_data_d;
  logic             st_valid_q, st_valid_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] nbytes;
  logic [LEN_W-1:0] hdr_shift;
  logic [1:0]       pair;
  logic             cov_ready;
  logic             cov_fire;
  logic             pay_fire;

  // Next-state, handshakes and output-register update.
  always_comb begin
    state_d      = state_q;
    sym_d        = sym_q;
    p_d          = p_q;
    h_d          = h_q;
    len_d        = len_q;
    hdr_d        = hdr_q;
    bytes_done_d = bytes_done_q;
    st_data_d    = st_data_q;
    st_valid_d   = st_valid_q;
    done_d       = 1'b0;

    // Fractional-byte bits of the length travel in the header only.
    nbytes    = len_q >> 3;
    hdr_shift = hdr_q << 8;

    case (p_q)
      2'd0:    pair = sym_q[7:6];
      2'd1:    pair = sym_q[5:4];
      2'd2:    pair = sym_q[3:2];
      default: pair = sym_q[1:0];
    endcase

    cov_ready = (state_q == S_HDR || state_q == S_EMBED || state_q == S_PASS) &&
                (!st_valid_q || st_ready_i);
    cov_fire  = cov_ready && cov_valid_i;
    pay_fire  = (state_q == S_LOAD) && pay_valid_i;

    if (cov_fire) begin
      st_valid_d = 1'b1;
      st_data_d  = (state_q == S_PASS) ? cov_data_i : {cov_data_i[7:2], pair};
    end else if (st_ready_i) begin
      st_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE, S_PASS: begin
        if (start_i) begin
          state_d      = S_HDR;
          len_d        = len_bits_i;
          hdr_d        = len_bits_i;
          sym_d        = len_bits_i[LEN_W-1 -: 8];
          h_d          = '0;
          p_d          = '0;
          bytes_done_d = '0;
        end
      end
      S_HDR: begin
        if (cov_fire) begin
          p_d = p_q + 2'd1;
          if (p_q == 2'd3) begin
            if (h_q == HW'(HDR_BYTES - 1)) begin
              if (nbytes != '0) begin
                state_d = S_LOAD;
              end else begin
                done_d  = 1'b1;
                state_d = S_EXIT;
              end
            end else begin
              h_d   = h_q + HW'(1);
              hdr_d = hdr_shift;
              sym_d = hdr_shift[LEN_W-1 -: 8];
            end
          end
        end
      end
      S_LOAD: begin
        if (pay_fire) begin
          sym_d   = pay_data_i;
          p_d     = '0;
          state_d = S_EMBED;
        end
      end
      S_EMBED: begin
        if (cov_fire) begin
          p_d = p_q + 2'd1;
          if (p_q == 2'd3) begin
            if (bytes_done_q != nbytes) bytes_done_d = bytes_done_q + LEN_W'(1);
            if (bytes_done_q + LEN_W'(1) == nbytes) begin
              done_d  = 1'b1;
              state_d = S_EXIT;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath, counters and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q        <= '0;
      p_q          <= '0;
      h_q          <= '0;
      len_q        <= '0;
      hdr_q        <= '0;
      bytes_done_q <= '0;
      st_data_q    <= '0;
      st_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sym_q        <= sym_d;
      p_q          <= p_d;
      h_q          <= h_d;
      len_q        <= len_d;
      hdr_q        <= hdr_d;
      bytes_done_q <= bytes_done_d;
      st_data_q    <= st_data_d;
      st_valid_q   <= st_valid_d;
      done_q       <= done_d;
    end
  end

  assign pay_ready_o  = (state_q == S_LOAD);
  assign cov_ready_o  = cov_ready;
  assign st_data_o    = st_data_q;
  assign st_valid_o   = st_valid_q;
  assign busy_o       = (state_q == S_HDR || state_q == S_LOAD || state_q == S_EMBED);
  assign done_o       = done_q;
  assign bytes_done_o = bytes_done_q;

endmodule

// File: tb/tb_stego_encoder.sv
// Directed bench for stego_encoder: vector table of whole jobs plus
// hand-written stall, starvation and mid-job reset sequences.
module tb_stego_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [23:0] len_bits_i;
  logic [7:0]  pay_data_i;
  logic        pay_valid_i;
  logic        pay_ready_o;
  logic [7:0]  cov_data_i;
  logic        cov_valid_i;
  logic        cov_ready_o;
  logic [7:0]  st_data_o;
  logic        st_valid_o;
  logic        st_ready_i;
  logic        busy_o;
  logic        done_o;
  logic [23:0] bytes_done_o;

  int errs   = 0;
  int checks = 0;

  stego_encoder #(.LEN_W(24), .PASS_THRU(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .len_bits_i   (len_bits_i),
    .pay_data_i   (pay_data_i),
    .pay_valid_i  (pay_valid_i),
    .pay_ready_o  (pay_ready_o),
    .cov_data_i   (cov_data_i),
    .cov_valid_i  (cov_valid_i),
    .cov_ready_o  (cov_ready_o),
    .st_data_o    (st_data_o),
    .st_valid_o   (st_valid_o),
    .st_ready_i   (st_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .bytes_done_o (bytes_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0]  len;
    logic [7:0]   cov;
    logic [15:0]  pay;
    logic [7:0]   nst;
    logic [7:0]   nbytes;
    logic         rnd;
    logic [159:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_st_valid"},   {31'd0, st_valid_o},  32'd0);
    chk({tag, "_st_data"},    {24'd0, st_data_o},   32'd0);
    chk({tag, "_pay_ready"},  {31'd0, pay_ready_o}, 32'd0);
    chk({tag, "_cov_ready"},  {31'd0, cov_ready_o}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy_o},      32'd0);
    chk({tag, "_done"},       {31'd0, done_o},      32'd0);
    chk({tag, "_bytes_done"}, {8'd0, bytes_done_o}, 32'd0);
  endtask

  // Called at a negedge: let the output register drain, then pulse start.
  task automatic start_job(input logic [23:0] len);
    cov_valid_i = 1'b0;
    pay_valid_i = 1'b0;
    st_ready_i  = 1'b1;
    repeat (3) @(negedge clk);
    start_i    = 1'b1;
    len_bits_i = len;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n, pi, dcnt, prs;
    logic stall;
    logic [7:0] prev, eb;
    logic [159:0] e;
    logic [15:0] pw;
    e = v.exp;
    pw = v.pay;
    start_job(v.len);
    chk($sformatf("v%0d_busy_after_start", idx), {31'd0, busy_o}, 32'd1);
    n = 0; pi = 0; dcnt = 0; prs = 0; stall = 1'b0; prev = 8'h00;
    for (int cyc = 0; cyc < 600 && n <= int'(v.nst); cyc++) begin
      st_ready_i  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cov_valid_i = 1'b1;
      cov_data_i  = v.cov;
      pay_valid_i = (pi < int'(v.nbytes));
      pay_data_i  = (pi == 0) ? pw[15:8] : pw[7:0];
      #1;
      if (stall) chk($sformatf("v%0d_stall_hold", idx), {23'd0, st_valid_o, st_data_o}, {23'd0, 1'b1, prev});
      if (done_o) dcnt++;
      if (pay_ready_o) prs++;
      if (pay_valid_i && pay_ready_o) pi++;
      if (st_valid_o && st_ready_i) begin
        if (n < int'(v.nst)) begin
          eb = e[159 - 8*n -: 8];
          chk($sformatf("v%0d_stego_byte%0d", idx, n), {24'd0, st_data_o}, {24'd0, eb});
        end else begin
          chk($sformatf("v%0d_pass_byte", idx), {24'd0, st_data_o}, {24'd0, v.cov});
        end
        n++;
      end
      stall = st_valid_o && !st_ready_i;
      prev  = st_data_o;
      @(negedge clk);
    end
    if (n <= int'(v.nst)) chk($sformatf("v%0d_timeout_bytes", idx), n, 32'(v.nst) + 1);
    chk($sformatf("v%0d_done_count", idx), dcnt, 32'd1);
    chk($sformatf("v%0d_bytes_done", idx), {8'd0, bytes_done_o}, {24'd0, v.nbytes});
    chk($sformatf("v%0d_pay_consumed", idx), pi, {24'd0, v.nbytes});
    if (v.nbytes == 8'd0) chk($sformatf("v%0d_pay_ready_seen", idx), prs, 32'd0);
    chk($sformatf("v%0d_busy_end", idx), {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int n;
    // len | cover | payload | stego bytes | payload bytes | random ready | expected stego
    vecs[0] = {24'd16, 8'hFF, 16'hA53C, 8'd20, 8'd2, 1'b0,
               {8{8'hFC}}, 8'hFC, 8'hFD, 8'hFC, 8'hFC, 8'hFE, 8'hFE, 8'hFD, 8'hFD,
               8'hFC, 8'hFF, 8'hFF, 8'hFC};
    vecs[1] = vecs[0];
    vecs[1].rnd = 1'b1;
    vecs[2] = {24'd0, 8'hFF, 16'h0000, 8'd12, 8'd0, 1'b0, {12{8'hFC}}, 64'h0};
    vecs[3] = {24'd13, 8'hFF, 16'h5A00, 8'd16, 8'd1, 1'b0,
               {8{8'hFC}}, 8'hFC, 8'hFC, 8'hFF, 8'hFD, 8'hFD, 8'hFD, 8'hFE, 8'hFE, 32'h0};
    vecs[4] = {24'd16, 8'h00, 16'hA53C, 8'd20, 8'd2, 1'b1,
               {8{8'h00}}, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h02, 8'h01, 8'h01,
               8'h00, 8'h03, 8'h03, 8'h00};
    vecs[5] = {24'd8, 8'h81, 16'hC300, 8'd16, 8'd1, 1'b0,
               {8{8'h80}}, 8'h80, 8'h80, 8'h82, 8'h80, 8'h83, 8'h80, 8'h80, 8'h83, 32'h0};

    rst_n = 1'b0; start_i = 1'b0; len_bits_i = '0; pay_data_i = '0; pay_valid_i = 1'b0;
    cov_data_i = '0; cov_valid_i = 1'b0; st_ready_i = 1'b1;
    #12;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Payload starvation: header goes out, then cover stalls and output drains.
    start_job(24'd16);
    n = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      st_ready_i  = 1'b1;
      cov_valid_i = 1'b1;
      cov_data_i  = 8'hFF;
      pay_valid_i = 1'b0;
      #1;
      if (st_valid_o && st_ready_i) n++;
      @(negedge clk);
    end
    #1;
    chk("starve_hdr_bytes", n, 32'd12);
    chk("starve_cov_ready", {31'd0, cov_ready_o}, 32'd0);
    chk("starve_st_valid", {31'd0, st_valid_o}, 32'd0);
    chk("starve_pay_ready", {31'd0, pay_ready_o}, 32'd1);
    chk("starve_busy", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    start_i = 1'b1;
    len_bits_i = 24'd0;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("busy_start_ignored", {31'd0, pay_ready_o}, 32'd1);

    // Reset mid-job after six stego bytes, then rerun the first job cleanly.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("rst_starve");
    @(negedge clk);
    rst_n = 1'b1;
    start_job(24'd16);
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      st_ready_i  = 1'b1;
      cov_valid_i = 1'b1;
      cov_data_i  = 8'hFF;
      #1;
      if (st_valid_o && st_ready_i) n++;
      @(negedge clk);
    end
    chk("midjob_bytes_before_reset", n, 32'd6);
    rst_n = 1'b0;
    #1;
    check_reset("rst_midjob");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], 6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
